// File: rtl/main_memory_wait_pkg.sv
// Shared types and helpers for the wait-state main memory controller.
// Byte lane 3 (bits 31:24) holds byte offset 0: the memory is big-endian.
package main_memory_wait_pkg;

    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

    localparam logic [1:0] SZ_WORD = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_BYTE = 2'b10;

    typedef struct packed {
        logic        rd;
        logic        wr;
        logic [1:0]  size;
        logic [31:0] addr;
        logic [31:0] wdata;
    } req_t;

    // Reserved size code counts as misaligned so one term covers both rejects.
    function automatic logic misaligned(input logic [1:0] size, input logic [1:0] off);
        case (size)
            SZ_WORD: return off != 2'b00;
            SZ_HALF: return off[0];
            SZ_BYTE: return 1'b0;
            default: return 1'b1;
        endcase
    endfunction

    function automatic logic [3:0] byte_en(input logic [1:0] size, input logic [1:0] off);
        case (size)
            SZ_WORD: return 4'b1111;
            SZ_HALF: return off[1] ? 4'b0011 : 4'b1100;
            SZ_BYTE: return 4'b1000 >> off;
            default: return 4'b0000;
        endcase
    endfunction

    // Replicate right-justified write data across lanes; byte enables pick the live ones.
    function automatic logic [31:0] wr_lanes(input logic [1:0] size, input logic [31:0] d);
        case (size)
            SZ_HALF: return {2{d[15:0]}};
            SZ_BYTE: return {4{d[7:0]}};
            default: return d;
        endcase
    endfunction

    function automatic logic [31:0] rd_extract(input logic [1:0] size, input logic [1:0] off,
                                               input logic [31:0] q);
        case (size)
            SZ_HALF: return off[1] ? {16'h0, q[15:0]} : {16'h0, q[31:16]};
            SZ_BYTE: return (q >> {~off, 3'b000}) & 32'h0000_00FF;
            default: return q;
        endcase
    endfunction

endpackage

// File: rtl/main_memory_wait_ctrl_if.sv
// Datapath-side bus of the main memory: A/B buses, RD/WR/size request, ACK/ERR/Busy/data response.
interface main_memory_wait_ctrl_if;
    logic [31:0] MEMCTRL_A_InBus;
    logic [31:0] MEMCTRL_B_InBus;
    logic        MEMCTRL_RD_In;
    logic        MEMCTRL_WRMain_In;
    logic [1:0]  MEMCTRL_Size_InBus;
    logic        MEMCTRL_ACK_Out;
    logic        MEMCTRL_ERR_Out;
    logic        MEMCTRL_Busy_Out;
    logic [31:0] MEMCTRL_Data_OutBus;

    modport master (
        output MEMCTRL_A_InBus, MEMCTRL_B_InBus, MEMCTRL_RD_In, MEMCTRL_WRMain_In,
               MEMCTRL_Size_InBus,
        input  MEMCTRL_ACK_Out, MEMCTRL_ERR_Out, MEMCTRL_Busy_Out, MEMCTRL_Data_OutBus
    );

    modport slave (
        input  MEMCTRL_A_InBus, MEMCTRL_B_InBus, MEMCTRL_RD_In, MEMCTRL_WRMain_In,
               MEMCTRL_Size_InBus,
        output MEMCTRL_ACK_Out, MEMCTRL_ERR_Out, MEMCTRL_Busy_Out, MEMCTRL_Data_OutBus
    );
endinterface

// File: rtl/main_memory_wait_ram.sv
module main_memory_wait_ram #(
  parameter int ADDR_WIDTH = 10,
  parameter     INIT_FILE  = ""
) (
  input  logic                  clk,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic                  we,
  input  logic [3:0]            be,
  input  logic [31:0]           wdata,
  output logic [31:0]           q
);
  localparam int DEPTH = 2 ** ADDR_WIDTH;

  logic [31:0] mem [DEPTH];

  initial for (int i = 0; i < DEPTH; i++) mem[i] = '0;

  always_ff @(posedge clk) begin
    for (int lane = 0; lane < 4; lane++)
      if (we && be[lane]) mem[addr][8*lane +: 8] <= wdata[8*lane +: 8];
    q <= mem[addr];
  end
endmodule

// File: rtl/main_memory_wait_ctrl.sv
// RD/WR -> ACK memory controller: latches the request, burns WAIT_STATES cycles,
// then answers for one cycle with ACK (and ERR for rejected accesses).
module main_memory_wait_ctrl
    import main_memory_wait_pkg::*;
#(
    parameter int DATAWIDTH_BUS = 32,
    parameter int ADDR_WIDTH    = 10,
    parameter int WAIT_STATES   = 2,
    parameter     INIT_FILE     = ""
) (
    input  logic                   MEMCTRL_CLOCK_50,
    input  logic                   MEMCTRL_ResetInLow_In,
    main_memory_wait_ctrl_if.slave bus
);
    localparam logic [3:0] WS_LOAD = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

    state_t                   state, state_nx;
    logic [3:0]               cnt, cnt_nx;
    req_t                     lat;
    logic [DATAWIDTH_BUS-1:0] data_hold;
    logic                     req_in, err, rd_ok, ram_we;
    logic [ADDR_WIDTH-1:0]    ram_addr;
    logic [31:0]              ram_q, rd_data;

    assign req_in = bus.MEMCTRL_RD_In | bus.MEMCTRL_WRMain_In;

    always_ff @(posedge MEMCTRL_CLOCK_50 or negedge MEMCTRL_ResetInLow_In) begin
        if (!MEMCTRL_ResetInLow_In) begin
            state     <= IDLE;
            cnt       <= '0;
            lat       <= '0;
            data_hold <= '0;
        end else begin
            state <= state_nx;
            cnt   <= cnt_nx;
            if (state == IDLE && req_in)
                lat <= '{rd:    bus.MEMCTRL_RD_In,
                         wr:    bus.MEMCTRL_WRMain_In,
                         size:  bus.MEMCTRL_Size_InBus,
                         addr:  bus.MEMCTRL_A_InBus,
                         wdata: bus.MEMCTRL_B_InBus};
            if (rd_ok) data_hold <= rd_data;
        end
    end

    always_comb begin
        state_nx = state;
        cnt_nx   = cnt;
        case (state)
            IDLE: if (req_in) begin
                if (WAIT_STATES > 0) begin
                    state_nx = WAIT;
                    cnt_nx   = WS_LOAD;
                end else begin
                    state_nx = RESP;
                end
            end
            WAIT: if (cnt == 4'd0) state_nx = RESP;
                  else             cnt_nx   = cnt - 4'd1;
            RESP:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    assign err = (lat.rd & lat.wr)
               | misaligned(lat.size, lat.addr[1:0])
               | ((lat.addr >> (ADDR_WIDTH + 2)) != 32'd0);

    // In IDLE the RAM reads straight off the A bus so a zero-wait access has data in RESP.
    assign ram_addr = (state == IDLE) ? bus.MEMCTRL_A_InBus[ADDR_WIDTH+1:2]
                                      : lat.addr[ADDR_WIDTH+1:2];
    assign ram_we   = (state == RESP) && lat.wr && !err;
    assign rd_ok    = (state == RESP) && lat.rd && !err;
    assign rd_data  = rd_extract(lat.size, lat.addr[1:0], ram_q);

    main_memory_wait_ram #(
        .ADDR_WIDTH(ADDR_WIDTH),
        .INIT_FILE (INIT_FILE)
    ) u_ram (
        .clk  (MEMCTRL_CLOCK_50),
        .addr (ram_addr),
        .we   (ram_we),
        .be   (byte_en(lat.size, lat.addr[1:0])),
        .wdata(wr_lanes(lat.size, lat.wdata)),
        .q    (ram_q)
    );

    assign bus.MEMCTRL_ACK_Out     = (state == RESP);
    assign bus.MEMCTRL_ERR_Out     = (state == RESP) && err;
    assign bus.MEMCTRL_Busy_Out    = (state != IDLE);
    assign bus.MEMCTRL_Data_OutBus = rd_ok ? rd_data : data_hold;
endmodule

// File: tb/tb_main_memory_wait_ctrl.sv
// Bench: byte-addressed reference model for the WAIT_STATES=2 instance, plus directed
// literal checks and a zero-wait instance for back-to-back handshake timing.
module tb_main_memory_wait_ctrl;
    localparam int WS = 2;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    main_memory_wait_ctrl_if bus2();
    main_memory_wait_ctrl_if bus0();

    main_memory_wait_ctrl #(.DATAWIDTH_BUS(32), .ADDR_WIDTH(10), .WAIT_STATES(WS), .INIT_FILE(""))
        dut (.MEMCTRL_CLOCK_50(clk), .MEMCTRL_ResetInLow_In(rst_n), .bus(bus2));
    main_memory_wait_ctrl #(.DATAWIDTH_BUS(32), .ADDR_WIDTH(10), .WAIT_STATES(0), .INIT_FILE(""))
        dut0 (.MEMCTRL_CLOCK_50(clk), .MEMCTRL_ResetInLow_In(rst_n), .bus(bus0));

    int n_pass = 0;
    int n_total = 0;
    bit started = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    endtask

    // ---------------- reference model: 4 KiB of big-endian bytes ----------------
    logic [7:0]  bmem [4096];
    int          cyc = 0, ack_cyc = 0;
    bit          pend = 1'b0;
    bit          p_rd, p_wr, p_err;
    logic [1:0]  p_size;
    logic [31:0] p_addr, p_wdata, p_rdata;
    logic        exp_ack = 1'b0, exp_err = 1'b0, exp_busy = 1'b0;
    logic [31:0] exp_data = '0;

    initial for (int i = 0; i < 4096; i++) bmem[i] = 8'h00;

    function automatic int nbytes(input logic [1:0] sz);
        return (sz == 2'd0) ? 4 : (sz == 2'd1) ? 2 : 1;
    endfunction

    function automatic logic [31:0] m_read(input logic [31:0] a, input logic [1:0] sz);
        logic [31:0] v = '0;
        for (int i = 0; i < nbytes(sz); i++) v = (v << 8) | 32'(bmem[a + i]);
        return v;
    endfunction

    function automatic bit m_err(input bit rd, input bit wr, input logic [1:0] sz,
                                 input logic [31:0] a);
        return (rd && wr) || sz == 2'd3 || (sz == 2'd1 && a % 2 != 0)
            || (sz == 2'd0 && a % 4 != 0) || a >= 32'd4096;
    endfunction

    // An access sampled at the edge opening cycle n answers in cycle n+WS; the cycle
    // after the answer is always idle, so the next sample is at cycle n+WS+2 or later.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pend = 1'b0; exp_ack = 1'b0; exp_err = 1'b0; exp_busy = 1'b0; exp_data = '0;
        end else begin
            cyc++;
            if (pend) begin
                if (cyc == ack_cyc + 1) begin
                    if (p_wr && !p_err)
                        for (int i = 0; i < nbytes(p_size); i++)
                            bmem[p_addr + i] = 8'(p_wdata >> (8 * (nbytes(p_size) - 1 - i)));
                    pend = 1'b0;
                end
            end else if (bus2.MEMCTRL_RD_In || bus2.MEMCTRL_WRMain_In) begin
                p_rd    = bus2.MEMCTRL_RD_In;
                p_wr    = bus2.MEMCTRL_WRMain_In;
                p_size  = bus2.MEMCTRL_Size_InBus;
                p_addr  = bus2.MEMCTRL_A_InBus;
                p_wdata = bus2.MEMCTRL_B_InBus;
                p_err   = m_err(p_rd, p_wr, p_size, p_addr);
                p_rdata = p_err ? 32'h0 : m_read(p_addr, p_size);
                ack_cyc = cyc + WS;
                pend    = 1'b1;
            end
            exp_busy = pend;
            exp_ack  = pend && cyc == ack_cyc;
            exp_err  = exp_ack && p_err;
            if (exp_ack && p_rd && !p_err) exp_data = p_rdata;
        end
    end

    always @(negedge clk) if (started) begin
        chk("ack",  32'(bus2.MEMCTRL_ACK_Out),  32'(exp_ack));
        chk("err",  32'(bus2.MEMCTRL_ERR_Out),  32'(exp_err));
        chk("busy", 32'(bus2.MEMCTRL_Busy_Out), 32'(exp_busy));
        chk("data", bus2.MEMCTRL_Data_OutBus,   exp_data);
    end

    // ---------------- directed helpers ----------------
    task automatic access(input bit rd, input bit wr, input logic [1:0] sz,
                          input logic [31:0] a, input logic [31:0] b,
                          output int lat, output logic err, output logic [31:0] data);
        bit got = 1'b0;
        @(posedge clk); #1;
        bus2.MEMCTRL_RD_In = rd; bus2.MEMCTRL_WRMain_In = wr;
        bus2.MEMCTRL_Size_InBus = sz; bus2.MEMCTRL_A_InBus = a; bus2.MEMCTRL_B_InBus = b;
        lat = 0; err = 1'bx; data = 'x;
        for (int i = 0; i < 20 && !got; i++) begin
            @(posedge clk); lat++;
            @(negedge clk);
            if (bus2.MEMCTRL_ACK_Out) begin
                got = 1'b1; err = bus2.MEMCTRL_ERR_Out; data = bus2.MEMCTRL_Data_OutBus;
            end
        end
        bus2.MEMCTRL_RD_In = 1'b0; bus2.MEMCTRL_WRMain_In = 1'b0;
        if (!got) chk("ack_timeout", 32'd0, 32'd1);
    endtask

    task automatic chk_zero_outputs(input string tag);
        chk({tag, "_ack"},  32'(bus2.MEMCTRL_ACK_Out),  32'd0);
        chk({tag, "_err"},  32'(bus2.MEMCTRL_ERR_Out),  32'd0);
        chk({tag, "_busy"}, 32'(bus2.MEMCTRL_Busy_Out), 32'd0);
        chk({tag, "_data"}, bus2.MEMCTRL_Data_OutBus,   32'd0);
    endtask

    int          lat, acks;
    logic        err;
    logic [31:0] data;
    logic [3:0]  ack_pat, busy_pat;

    initial begin
        bus2.MEMCTRL_RD_In = 0; bus2.MEMCTRL_WRMain_In = 0; bus2.MEMCTRL_Size_InBus = 0;
        bus2.MEMCTRL_A_InBus = 0; bus2.MEMCTRL_B_InBus = 0;
        bus0.MEMCTRL_RD_In = 0; bus0.MEMCTRL_WRMain_In = 0; bus0.MEMCTRL_Size_InBus = 0;
        bus0.MEMCTRL_A_InBus = 0; bus0.MEMCTRL_B_InBus = 0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk_zero_outputs("reset");
        #2 rst_n = 1'b1;
        started = 1'b1;

        access(0, 1, 2'd0, 32'h10, 32'hDEADBEEF, lat, err, data);
        chk("wr_word_lat", 32'(lat), 32'd3);
        chk("wr_word_err", 32'(err), 32'd0);
        access(1, 0, 2'd0, 32'h10, 32'h0, lat, err, data);
        chk("rd_word_lat", 32'(lat), 32'd3);
        chk("rd_word", data, 32'hDEADBEEF);
        access(0, 1, 2'd2, 32'h11, 32'hAA, lat, err, data);
        access(1, 0, 2'd0, 32'h10, 32'h0, lat, err, data);
        chk("rd_after_byte_wr", data, 32'hDEAABEEF);
        access(1, 0, 2'd2, 32'h13, 32'h0, lat, err, data);
        chk("rd_byte_13", data, 32'h000000EF);
        access(1, 0, 2'd1, 32'h12, 32'h0, lat, err, data);
        chk("rd_half_12", data, 32'h0000BEEF);
        access(1, 0, 2'd1, 32'h11, 32'h0, lat, err, data);
        chk("half_misaligned_err", 32'(err), 32'd1);
        chk("half_misaligned_lat", 32'(lat), 32'd3);
        chk("half_misaligned_data_kept", data, 32'h0000BEEF);
        access(1, 1, 2'd0, 32'h10, 32'h11111111, lat, err, data);
        chk("rd_wr_both_err", 32'(err), 32'd1);
        access(0, 1, 2'd0, 32'h00010000, 32'h22222222, lat, err, data);
        chk("out_of_range_err", 32'(err), 32'd1);
        access(1, 0, 2'd0, 32'h10, 32'h0, lat, err, data);
        chk("reread_after_errs", data, 32'hDEAABEEF);
        chk("reread_err", 32'(err), 32'd0);

        // Reset in the middle of a write's wait window.
        @(posedge clk); #1;
        bus2.MEMCTRL_WRMain_In = 1; bus2.MEMCTRL_Size_InBus = 2'd0;
        bus2.MEMCTRL_A_InBus = 32'h10; bus2.MEMCTRL_B_InBus = 32'h12345678;
        @(posedge clk);
        @(negedge clk);
        chk("busy_in_wait", 32'(bus2.MEMCTRL_Busy_Out), 32'd1);
        #2 rst_n = 1'b0;
        #1 chk_zero_outputs("midreset");
        bus2.MEMCTRL_WRMain_In = 0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        #2 rst_n = 1'b1;
        acks = 0;
        repeat (6) begin @(negedge clk); if (bus2.MEMCTRL_ACK_Out) acks++; end
        chk("no_ack_after_abort", 32'(acks), 32'd0);
        access(1, 0, 2'd0, 32'h10, 32'h0, lat, err, data);
        chk("old_data_after_abort", data, 32'hDEAABEEF);

        // Zero wait states: a held read answers every second cycle.
        @(posedge clk); #1;
        bus0.MEMCTRL_RD_In = 1; bus0.MEMCTRL_A_InBus = 32'h10;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); @(negedge clk);
            ack_pat[3-i]  = bus0.MEMCTRL_ACK_Out;
            busy_pat[3-i] = bus0.MEMCTRL_Busy_Out;
        end
        bus0.MEMCTRL_RD_In = 0;
        chk("ws0_ack_pattern",  32'(ack_pat),  32'hA);
        chk("ws0_busy_pattern", 32'(busy_pat), 32'hA);
        acks = 0;
        repeat (4) begin @(negedge clk); if (bus0.MEMCTRL_ACK_Out) acks++; end
        chk("ws0_quiet_after_drop", 32'(acks), 32'd0);

        // Randomised traffic against the model, including held and back-to-back requests.
        for (int c = 0; c < 2000; c++) begin
            @(posedge clk); #1;
            if ($urandom_range(0, 3) == 0) begin
                bus2.MEMCTRL_RD_In = 0; bus2.MEMCTRL_WRMain_In = 0;
            end else begin
                int k = $urandom_range(0, 19);
                int s = $urandom_range(0, 9);
                logic [31:0] a = 32'($urandom_range(0, 63));
                bus2.MEMCTRL_RD_In     = (k < 10) || (k == 19);
                bus2.MEMCTRL_WRMain_In = (k >= 10);
                bus2.MEMCTRL_Size_InBus = (s < 4) ? 2'd0 : (s < 7) ? 2'd1 : (s < 9) ? 2'd2 : 2'd3;
                if ($urandom_range(0, 6) != 0)
                    a = (s < 4) ? (a & ~32'h3) : (s < 7) ? (a & ~32'h1) : a;
                if ($urandom_range(0, 15) == 0) a = $urandom;
                bus2.MEMCTRL_A_InBus = a;
                bus2.MEMCTRL_B_InBus = $urandom;
            end
        end
        bus2.MEMCTRL_RD_In = 0; bus2.MEMCTRL_WRMain_In = 0;
        repeat (10) @(posedge clk);
        @(negedge clk);
        started = 1'b0;
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
